// File: rtl/datapath_ctrl.sv
// Control sequencer for the 32x64 register-file/ALU datapath: decodes handshaked
// instruction words into registered control words. Optional SKZ op: DATAPATH_CTRL_SKIP_EN.
module datapath_ctrl #(
    parameter int K_W   = 64,
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [31:0]      instr,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [3:0]       status,
    output logic [4:0]       FS,
    output logic [4:0]       AA,
    output logic [4:0]       BA,
    output logic [4:0]       DA,
    output logic [K_W-1:0]   K,
    output logic             cin,
    output logic             Bselect,
    output logic             write,
    output logic             EN_B,
    output logic             EN_ALU,
    output logic [3:0]       flags,
    output logic             busy,
    output logic             err,
    output logic [1:0]       dbg_state
);

    // Handshake: a transfer happens at a rising edge where instr_valid && instr_ready.
    // instr_ready is registered and high only in IDLE; the source holds instr until then.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        REP  = 2'd2
    } state_t;

    typedef struct packed {
        logic [4:0]     fs;
        logic [4:0]     aa;
        logic [4:0]     ba;
        logic [4:0]     da;
        logic [K_W-1:0] k;
        logic           cin;
        logic           bsel;
        logic           wr;
        logic           en_b;
        logic           en_alu;
    } ctl_t;

    localparam logic [3:0] OP_NOP    = 4'd0;
    localparam logic [3:0] OP_ALU_R  = 4'd1;
    localparam logic [3:0] OP_ALU_I  = 4'd2;
    localparam logic [3:0] OP_MOV    = 4'd3;
    localparam logic [3:0] OP_CMP    = 4'd4;
    localparam logic [3:0] OP_ALU_RC = 4'd5;
    localparam logic [3:0] OP_REP    = 4'd6;
`ifdef DATAPATH_CTRL_SKIP_EN
    localparam logic [3:0] OP_SKZ    = 4'd7;
`endif

    state_t           state, state_n;
    ctl_t             ctl_q, ctl_n, dec;
    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic [3:0]       op_q, op_n;
    logic [3:0]       flags_q, flags_n;
    logic             err_q, err_n;
    logic             ready_q, ready_n;
    logic             xfer;
    logic             skip_act;
    logic [3:0]       op;
    logic [7:0]       imm8;

`ifdef DATAPATH_CTRL_SKIP_EN
    logic skip_q, skip_n;
    assign skip_act = skip_q;
`else
    assign skip_act = 1'b0;
`endif

    assign op   = instr[31:28];
    assign imm8 = instr[7:0];
    assign xfer = instr_valid && ready_q;

    // Register addresses and function come straight from the instruction word.
    always_comb begin
        dec    = '0;
        dec.da = instr[27:23];
        dec.aa = instr[22:18];
        dec.ba = instr[17:13];
        dec.fs = instr[12:8];
    end

    always_comb begin
        state_n = state;
        ctl_n   = '0;
        cnt_n   = cnt_q;
        op_n    = op_q;
        flags_n = flags_q;
        err_n   = 1'b0;
`ifdef DATAPATH_CTRL_SKIP_EN
        skip_n  = skip_q;
`endif
        case (state)
            IDLE: begin
                if (xfer && skip_act) begin
`ifdef DATAPATH_CTRL_SKIP_EN
                    skip_n = 1'b0;
`endif
                end else if (xfer) begin
                    op_n = op;
                    case (op)
                        OP_NOP: ;
                        OP_ALU_R, OP_ALU_RC: begin
                            state_n      = EXEC;
                            ctl_n        = dec;
                            ctl_n.en_alu = 1'b1;
                            ctl_n.wr     = 1'b1;
                            ctl_n.cin    = (op == OP_ALU_RC) ? flags_q[2] : 1'b0;
                        end
                        OP_ALU_I: begin
                            state_n      = EXEC;
                            ctl_n        = dec;
                            ctl_n.bsel   = 1'b1;
                            ctl_n.k      = {{(K_W-8){imm8[7]}}, imm8};
                            ctl_n.en_alu = 1'b1;
                            ctl_n.wr     = 1'b1;
                        end
                        OP_MOV: begin
                            state_n    = EXEC;
                            ctl_n      = dec;
                            ctl_n.en_b = 1'b1;
                            ctl_n.wr   = 1'b1;
                        end
                        OP_CMP: begin
                            state_n = EXEC;
                            ctl_n   = dec;
                        end
                        OP_REP: begin
                            if (imm8 != 8'd0) begin
                                state_n      = REP;
                                cnt_n        = CNT_W'(imm8);
                                ctl_n        = dec;
                                ctl_n.bsel   = 1'b1;
                                ctl_n.k      = K_W'(1);
                                ctl_n.en_alu = 1'b1;
                                ctl_n.wr     = 1'b1;
                            end
                        end
`ifdef DATAPATH_CTRL_SKIP_EN
                        OP_SKZ: begin
                            if (flags_q[0]) skip_n = 1'b1;
                        end
`endif
                        default: err_n = 1'b1;
                    endcase
                end
            end
            EXEC: begin
                state_n = IDLE;
                if (op_q != OP_MOV) flags_n = status;
            end
            REP: begin
                // Control word is held; the last iteration clears it at its closing edge.
                flags_n = status;
                ctl_n   = ctl_q;
                cnt_n   = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_n = IDLE;
                    ctl_n   = '0;
                end
            end
            default: state_n = IDLE;
        endcase
        ready_n = (state_n == IDLE);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state   <= IDLE;
            ctl_q   <= '0;
            cnt_q   <= '0;
            op_q    <= '0;
            flags_q <= '0;
            err_q   <= 1'b0;
            ready_q <= 1'b0;
`ifdef DATAPATH_CTRL_SKIP_EN
            skip_q  <= 1'b0;
`endif
        end else begin
            state   <= state_n;
            ctl_q   <= ctl_n;
            cnt_q   <= cnt_n;
            op_q    <= op_n;
            flags_q <= flags_n;
            err_q   <= err_n;
            ready_q <= ready_n;
`ifdef DATAPATH_CTRL_SKIP_EN
            skip_q  <= skip_n;
`endif
        end
    end

    assign instr_ready = ready_q;
    assign FS          = ctl_q.fs;
    assign AA          = ctl_q.aa;
    assign BA          = ctl_q.ba;
    assign DA          = ctl_q.da;
    assign K           = ctl_q.k;
    assign cin         = ctl_q.cin;
    assign Bselect     = ctl_q.bsel;
    assign write       = ctl_q.wr;
    assign EN_B        = ctl_q.en_b;
    assign EN_ALU      = ctl_q.en_alu;
    assign flags       = flags_q;
    assign err         = err_q;
    assign busy        = (state != IDLE);
    assign dbg_state   = state;

endmodule

// File: doc/datapath_ctrl.md
Name: datapath_ctrl

Overview:
- Control sequencer that drives the control-word inputs of the 32x64 register-file/ALU datapath: FS, AA, BA, DA, K, cin, Bselect, write, EN_B and EN_ALU.
- Accepts encoded instructions over a valid/ready handshake and decodes them into one or more execute cycles.
- Captures ALU status flags and exposes them.
- Sits between the instruction source (testbench or future fetch unit) and the datapath.

Parameters:
- K_W, 64, width of the K constant output; imm8 is sign-extended to this width.
- CNT_W, 8, width of the repeat counter for the REP opcode.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-low reset
- instr  input  32  instruction word: [31:28] op, [27:23] DA, [22:18] AA, [17:13] BA, [12:8] FS, [7:0] imm8
- instr_valid  input  1  instr is valid this cycle
- instr_ready  output  1  controller can accept instr
- status  input  4  ALU status {V,C,N,Z}, valid during the execute cycle
- FS  output  5  ALU function select
- AA  output  5  register A read address
- BA  output  5  register B read address
- DA  output  5  register write address
- K  output  K_W  constant for the B mux
- cin  output  1  ALU carry-in
- Bselect  output  1  0 = regB, 1 = K
- write  output  1  register-file write enable
- EN_B  output  1  drive regB onto bus
- EN_ALU  output  1  drive ALU result onto bus
- flags  output  4  last captured {V,C,N,Z}
- busy  output  1  high while not IDLE
- err  output  1  one-cycle pulse on an illegal opcode

Behaviour:
- Reset (reset=0 at a clock edge): state is IDLE; every output and the flags register are 0, including instr_ready.
- instr_ready rises the first cycle after reset is released.
- FSM states: IDLE, EXEC, REP.
- IDLE:
  - instr_ready=1 and busy=0; all control outputs are 0, so write=0 and both bus enables are 0.
  - A transfer occurs when instr_valid && instr_ready at the clock edge. The instruction is latched and the control outputs are registered at that same edge.
- Next state after a transfer:
  - op 0 NOP: stay in IDLE, no control activity.
  - op 1 ALU_R: EXEC with Bselect=0, EN_ALU=1, write=1, cin=0.
  - op 2 ALU_I: EXEC with Bselect=1, K=sext(imm8), EN_ALU=1, write=1, cin=0.
  - op 3 MOV: EXEC with EN_B=1, EN_ALU=0, write=1; DA receives regB.
  - op 4 CMP: EXEC with Bselect=0, EN_ALU=0, EN_B=0, write=0.
  - op 5 ALU_RC: as ALU_R, but cin=flags[2].
  - op 6 REP: if imm8==0, stay in IDLE (no-op). Otherwise load the counter with imm8, go to REP with Bselect=1, K=1, EN_ALU=1, write=1.
  - Any other op: err=1 for one cycle, stay in IDLE, instruction consumed.
- EXEC lasts exactly one cycle:
  - instr_ready=0, busy=1.
  - The register write happens at the closing edge.
  - For ops 1, 2, 4 and 5, flags<=status at that edge; MOV leaves flags unchanged.
  - Next state is IDLE, with all control outputs cleared at that edge.
- REP:
  - Issues DA <= AA FS 1 once per cycle, for imm8 cycles total; flags are updated every cycle.
  - The counter decrements each cycle; when it reaches 1 at a clock edge, next state is IDLE.
  - AA is not rewritten to DA between iterations; for accumulation, software sets AA==DA.
- Throughput: one single-cycle op per 2 clocks; REP with count n occupies n+1 clocks including the accept cycle.
- Invariants, checked every cycle:
  - EN_B && EN_ALU is never 1.
  - write=1 only in EXEC or REP.
  - err never coincides with write.
- Reset during EXEC or REP: abort at that edge; no further writes; outputs go to their reset values; flags=0.
- instr_valid while instr_ready=0 is ignored; the source must hold the instruction.

Optional Feature:
- Macro: DATAPATH_CTRL_SKIP_EN.
- Defined:
  - op 7 SKZ sets an internal skip flag when flags[0] (Z) is 1; no datapath activity, stays in IDLE.
  - The next accepted instruction is consumed with no control activity and no err, even if its opcode is illegal; the skip flag is then cleared.
  - Reset clears the skip flag.
- Not defined: op 7 is illegal and pulses err.

Test Plan:
- Reset: hold reset=0 for 3 cycles, then release → all outputs 0 during reset; instr_ready=1 one cycle after release; flags=0.
- ALU_I: op=2, DA=3, AA=0, FS=ADD, imm8=0xFF → in the EXEC cycle K=64'hFFFF_FFFF_FFFF_FFFF, Bselect=1, EN_ALU=1, write=1; instr_ready=0; back to IDLE the next cycle.
- MOV then CMP: MOV DA=5, BA=3 → EN_B=1, EN_ALU=0, write=1. CMP with status=4'b0001 → write=0; flags=4'b0001 after the edge.
- REP: op=6, imm8=4, AA=DA=7 → write=1 for exactly 4 consecutive cycles with K=1; busy for 4 cycles; r7 increases by 4. imm8=0 → zero writes.
- Reset mid-REP: imm8=10, assert reset after 3 write cycles → write=0 from the next edge; state IDLE after release.
- Illegal op=9 → one-cycle err=1, no write, instr_ready stays 1. With DATAPATH_CTRL_SKIP_EN and Z=1: SKZ followed by ALU_R → no write for the ALU_R.
